// File: rtl/pipelined_adder_nb_if.sv
// pipelined_adder_nb_if: operand/result handshake bundle for pipelined_adder_nb.
// Ports: in_valid/in_ready/i1/i2/cin/sub (operand side) and
//        out_valid/out_ready/s/c/ovf (result side).
// Modports: master drives operands and consumes results; slave is the adder.
interface pipelined_adder_nb_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

  modport master (
    output in_valid, i1, i2, cin, sub, out_ready,
    input  in_ready, out_valid, s, c, ovf
  );

  modport slave (
    input  in_valid, i1, i2, cin, sub, out_ready,
    output in_ready, out_valid, s, c, ovf
  );
endinterface

// File: rtl/pipelined_adder_nb.sv
// Purpose: elastic adder/subtractor, operands split into STAGES chunks of CW bits, one chunk per stage.
// Latency: beat accepted at edge n is presented on out_valid after edge n+STAGES-1; 1 beat/cycle.
// Backpressure: stages fill bubble-first under out_ready=0; in_ready drops only when every stage is full and stalled.
// Ports: clk, rst_n (sync, active-low); bus (slave modport): in_valid/in_ready/i1/i2/cin/sub in,
//        out_valid/out_ready/s/c/ovf out. s wraps modulo 2^WIDTH, c is MSB carry (1 = no borrow on sub),
//        ovf is two's-complement overflow.
module pipelined_adder_nb #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_adder_nb_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  // CW-bit ripple of full adders; returns {carry_out, sum}.
  function automatic logic [CW:0] chunk_add(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b,
    input logic          ci
  );
    logic          cy;
    logic [CW-1:0] sm;
    cy = ci;
    sm = '0;
    for (int j = 0; j < CW; j++) begin
      sm[j] = a[j] ^ b[j] ^ cy;
      cy    = (a[j] & b[j]) | (cy & (a[j] ^ b[j]));
    end
    return {cy, sm};
  endfunction

  // Subtract is a + ~b + ~borrow_in, so both preprocessing steps happen at acceptance.
  logic [WIDTH-1:0] b_pre;
  logic             c0;
  logic             in_rdy;

  assign b_pre = bus.sub ? ~bus.i2 : bus.i2;
  assign c0    = bus.sub ^ bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RIN = WIDTH - k * CW;   // operand bits still to be added when entering stage k
    localparam int SW  = (k + 1) * CW;     // completed sum bits held by stage k

    logic             vld_q;
    logic             cy_q;
    logic [SW-1:0]    sum_q;
    logic             ld;
    logic             adv;
    logic [RIN-1:0]   src_a;
    logic [RIN-1:0]   src_b;
    logic             ci;
    logic [CW:0]      res;
    logic [SW-1:0]    nsum;

    if (k == 0) begin : g_src
      assign ld    = bus.in_valid && in_rdy;
      assign src_a = bus.i1;
      assign src_b = b_pre;
      assign ci    = c0;
      assign nsum  = res[CW-1:0];
    end else begin : g_src
      assign ld    = g_st[k-1].adv;
      assign src_a = g_st[k-1].g_fwd.a_q;
      assign src_b = g_st[k-1].g_fwd.b_q;
      assign ci    = g_st[k-1].cy_q;
      assign nsum  = {res[CW-1:0], g_st[k-1].sum_q};
    end

    assign res = chunk_add(src_a[CW-1:0], src_b[CW-1:0], ci);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (ld) begin
        vld_q <= 1'b1;
        cy_q  <= res[CW];
        sum_q <= nsum;
      end else if (adv) begin
        vld_q <= 1'b0;
      end
    end

    // Upper chunks ride along unchanged so they meet their carry one stage later.
    if (k < STAGES - 1) begin : g_fwd
      logic [RIN-CW-1:0] a_q;
      logic [RIN-CW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= src_a[RIN-1:CW];
          b_q <= src_b[RIN-1:CW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      // Carry into the MSB equals a^b^sum at that bit; ovf is that XOR the carry out.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld) begin
          ovf_q <= res[CW] ^ (src_a[CW-1] ^ src_b[CW-1] ^ res[CW-1]);
        end
      end
      assign adv = vld_q && bus.out_ready;
    end else begin : g_mid
      // A stage may move on if the next one is empty or is itself moving on.
      assign adv = vld_q && (!g_st[k+1].vld_q || g_st[k+1].adv);
    end
  end

  assign in_rdy        = !g_st[0].vld_q || g_st[0].adv;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = g_st[STAGES-1].vld_q;
  assign bus.s         = g_st[STAGES-1].sum_q;
  assign bus.c         = g_st[STAGES-1].cy_q;
  assign bus.ovf       = g_st[STAGES-1].g_last.ovf_q;
endmodule
